// File: rtl/store_pkg.sv
// Shared types for the store read-modify-write unit: op codes, FSM states, lane mask.
package store_pkg;

  localparam int unsigned LaneW = 4;

  typedef logic [LaneW-1:0] lane_mask_t;

  localparam lane_mask_t LaneAll = '1;

  typedef enum logic [1:0] {
    OpSw  = 2'b00,
    OpSh  = 2'b01,
    OpSb  = 2'b10,
    OpIll = 2'b11
  } store_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRead  = 2'b01,
    StWrite = 2'b10,
    StErr   = 2'b11
  } store_state_e;

  // Illegal op, or a word/half store that is not naturally aligned.
  function automatic logic is_rejected(store_op_e op, logic [1:0] lo);
    return (op == OpIll) || ((op == OpSw) && (lo != 2'b00)) || ((op == OpSh) && lo[0]);
  endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Request and RAM-side bus of the store RMW unit; master is the environment, slave the unit.
interface store_rmw_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic [29:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        err;

  modport master (
    output req_valid, req_addr, req_data, req_op, mem_rdata,
    input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mem_be, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_op, mem_rdata,
    output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mem_be, done, err
  );

endinterface

// File: rtl/store_merge.sv
// Combinational lane-mask generation and byte merge of new store data into an old RAM word.
module store_merge
  import store_pkg::*;
(
  input  logic [1:0]  addr,
  input  store_op_e   op,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output lane_mask_t  be,
  output logic [31:0] merged
);

  logic [31:0] repl;

  always_comb begin
    be     = '0;
    repl   = new_data;
    merged = old_word;
    case (op)
      OpSw: be = LaneAll;
      OpSh: begin
        be   = addr[1] ? 4'b1100 : 4'b0011;
        repl = {2{new_data[15:0]}};
      end
      OpSb: begin
        be   = lane_mask_t'(1) << addr;
        repl = {4{new_data[7:0]}};
      end
      default: be = '0;
    endcase
    for (int i = 0; i < LaneW; i++) begin
      if (be[i]) merged[8*i +: 8] = repl[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a word-only synchronous RAM: SW writes directly, SH/SB read-modify-write.
module store_rmw_unit
  import store_pkg::*;
(
  input logic             clk,
  input logic             reset,
  store_rmw_unit_if.slave bus
);

  store_state_e state_q;
  logic         ready_q;
  logic         rd_q;
  logic         wr_q;
  logic         done_q;
  logic         err_q;
  lane_mask_t   be_q;
  logic [31:0]  wdata_q;
  logic [31:0]  addr_q;
  logic [31:0]  data_q;
  store_op_e    op_q;

  store_op_e    req_op;
  lane_mask_t   merge_be;
  logic [31:0]  merged;

  assign req_op = store_op_e'(bus.req_op);

  store_merge u_merge (
    .addr     (addr_q[1:0]),
    .op       (op_q),
    .old_word (bus.mem_rdata),
    .new_data (data_q),
    .be       (merge_be),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= OpSw;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.req_valid && ready_q) begin
            addr_q  <= bus.req_addr;
            data_q  <= bus.req_data;
            op_q    <= req_op;
            ready_q <= 1'b0;
            if (is_rejected(req_op, bus.req_addr[1:0])) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else if (req_op == OpSw) begin
              state_q <= StWrite;
              wr_q    <= 1'b1;
              done_q  <= 1'b1;
              be_q    <= LaneAll;
              wdata_q <= bus.req_data;
            end else begin
              state_q <= StRead;
              rd_q    <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        StRead: begin
          state_q <= StWrite;
          wr_q    <= 1'b1;
          done_q  <= 1'b1;
          be_q    <= merge_be;
        end
        StWrite: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          be_q    <= '0;
          wdata_q <= '0;
        end
        StErr: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.mem_addr  = addr_q[31:2];
  assign bus.mem_rd_en = rd_q;
  assign bus.mem_wr_en = wr_q;
  assign bus.mem_be    = be_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  // Sub-word stores merge into the word the RAM returns during WRITE.
  assign bus.mem_wdata = ((state_q == StWrite) && (op_q != OpSw)) ? merged : wdata_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit with hand-computed expectations.
module tb_store_rmw_unit;

  logic clk = 1'b0;
  logic reset;
  int   passes = 0;
  int   total  = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   both_cnt = 0;
  int   wr_base;

  store_rmw_unit_if bus ();

  store_rmw_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1) wr_cnt++;
    if (bus.mem_rd_en === 1'b1) rd_cnt++;
    if (bus.mem_wr_en === 1'b1 && bus.mem_rd_en === 1'b1) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_data  = d;
  endtask

  task automatic chk_err(input string tag);
    tick();
    chk({tag, "_err"}, {31'd0, bus.err}, 32'd1);
    chk({tag, "_rd"}, {31'd0, bus.mem_rd_en}, 32'd0);
    chk({tag, "_wr"}, {31'd0, bus.mem_wr_en}, 32'd0);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk({tag, "_err_clr"}, {31'd0, bus.err}, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    bus.mem_rdata = 32'h1122_3344;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rd", {31'd0, bus.mem_rd_en}, 32'd0);
    chk("rst_wr", {31'd0, bus.mem_wr_en}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_addr", {2'd0, bus.mem_addr}, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_ready", {31'd0, bus.req_ready}, 32'd1);

    // SW aligned: write one cycle after transfer
    drive(1'b1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    chk("sw_wr", {31'd0, bus.mem_wr_en}, 32'd1);
    chk("sw_addr", {2'd0, bus.mem_addr}, 32'h4);
    chk("sw_be", {28'd0, bus.mem_be}, 32'hF);
    chk("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("sw_done", {31'd0, bus.done}, 32'd1);
    chk("sw_ready", {31'd0, bus.req_ready}, 32'd0);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk("sw_wr_clr", {31'd0, bus.mem_wr_en}, 32'd0);
    chk("sw_rd_none", rd_cnt, 32'd0);

    // SB to lane 3
    drive(1'b1, 2'b10, 32'h0000_0013, 32'h0000_00AA);
    tick();
    chk("sb_rd", {31'd0, bus.mem_rd_en}, 32'd1);
    chk("sb_rd_addr", {2'd0, bus.mem_addr}, 32'h4);
    chk("sb_rd_nowr", {31'd0, bus.mem_wr_en}, 32'd0);
    drive(1'b1, 2'b00, 32'hFFFF_FFF0, 32'h0);
    tick();
    chk("sb_wr", {31'd0, bus.mem_wr_en}, 32'd1);
    chk("sb_rd_clr", {31'd0, bus.mem_rd_en}, 32'd0);
    chk("sb_be", {28'd0, bus.mem_be}, 32'h8);
    chk("sb_wdata", bus.mem_wdata, 32'hAA22_3344);
    chk("sb_addr_held", {2'd0, bus.mem_addr}, 32'h4);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();

    // SH to upper half
    drive(1'b1, 2'b01, 32'h0000_0022, 32'h0000_5566);
    tick();
    chk("sh_rd", {31'd0, bus.mem_rd_en}, 32'd1);
    chk("sh_addr", {2'd0, bus.mem_addr}, 32'h8);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk("sh_wr", {31'd0, bus.mem_wr_en}, 32'd1);
    chk("sh_be", {28'd0, bus.mem_be}, 32'hC);
    chk("sh_wdata", bus.mem_wdata, 32'h5566_3344);
    tick();

    // Rejected requests
    wr_base = wr_cnt;
    drive(1'b1, 2'b00, 32'h0000_0006, 32'h1234_5678);
    chk_err("sw_misal");
    drive(1'b1, 2'b01, 32'h0000_0001, 32'h1234_5678);
    chk_err("sh_misal");
    drive(1'b1, 2'b11, 32'h0000_0000, 32'h1234_5678);
    chk_err("op_ill");
    chk("err_no_wr", wr_cnt - wr_base, 32'd0);

    // Reset during READ aborts the store
    wr_base = wr_cnt;
    drive(1'b1, 2'b10, 32'h0000_0010, 32'h0000_0077);
    tick();
    chk("abort_rd", {31'd0, bus.mem_rd_en}, 32'd1);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    reset = 1'b0;
    tick();
    chk("abort_nowr", {31'd0, bus.mem_wr_en}, 32'd0);
    chk("abort_ready", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    tick();
    chk("abort_rel_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    chk("abort_wr_cnt", wr_cnt - wr_base, 32'd0);

    // req_valid held high: SW, SB, SW accepted at T, T+2, T+5
    wr_base = wr_cnt;
    drive(1'b1, 2'b00, 32'h0000_0000, 32'h0102_0304);
    tick();
    chk("b2b_sw1_be", {28'd0, bus.mem_be}, 32'hF);
    chk("b2b_sw1_wd", bus.mem_wdata, 32'h0102_0304);
    tick();
    chk("b2b_idle1_ready", {31'd0, bus.req_ready}, 32'd1);
    drive(1'b1, 2'b10, 32'h0000_0001, 32'h0000_00CC);
    tick();
    chk("b2b_sb_rd", {31'd0, bus.mem_rd_en}, 32'd1);
    chk("b2b_sb_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk("b2b_sb_be", {28'd0, bus.mem_be}, 32'h2);
    chk("b2b_sb_wd", bus.mem_wdata, 32'h1122_CC44);
    drive(1'b1, 2'b00, 32'h0000_0008, 32'hCAFE_F00D);
    tick();
    chk("b2b_idle2_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b_idle2_wr", {31'd0, bus.mem_wr_en}, 32'd0);
    tick();
    chk("b2b_sw2_wr", {31'd0, bus.mem_wr_en}, 32'd1);
    chk("b2b_sw2_addr", {2'd0, bus.mem_addr}, 32'h2);
    chk("b2b_sw2_wd", bus.mem_wdata, 32'hCAFE_F00D);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    tick();
    chk("b2b_wr_cnt", wr_cnt - wr_base, 32'd3);
    chk("never_rd_wr", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
